// File: rtl/inv_shift_rows_stage.sv
// inv_shift_rows_stage
//   AES InvShiftRows pipeline stage feeding mix_col. Each incoming state is
//   shifted on the input side and stored in a 2-entry FIFO of {state, tag}.
//   The FIFO decouples the upstream and downstream ready/valid handshakes.
//
// Ports
//   clk        single clock; every register updates on its rising edge
//   reset      asynchronous active-high reset
//   flush      synchronous discard of all buffered entries
//   in_valid   upstream state present
//   in_ready   stage can accept a state (registered count only)
//   in_state   AES state, byte k = bits [8k:8k+7], byte index 4c+r
//   in_tag     round tag, carried through unchanged
//   out_valid  shifted state present at the head
//   out_ready  downstream accepts the head entry
//   i_shift    InvShiftRows result at the head, same ordering as in_state
//   out_tag    tag of the head entry
//   occupancy  number of buffered entries (0..2)

module inv_shift_rows_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_state,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      i_shift,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);

  // Output byte 4c+r takes input byte 4*((c-r) mod 4)+r: row r rotates
  // right by r columns, row 0 stays in place.
  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[8*(4*c+row) +: 8] = s[8*(4*((c + 4 - row) % 4) + row) +: 8];
      end
    end
    return r;
  endfunction

  logic [0:127]     shifted;
  logic [0:127]     state_mem [2];
  logic [TAG_W-1:0] tag_mem   [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             ready_en;
  logic             push;
  logic             pop;

  always_comb begin
    shifted = inv_shift_rows(in_state);
  end

  // ready_en holds in_ready low while reset is asserted and releases it at
  // the first edge afterwards, keeping in_ready purely register-derived.
  always_comb begin
    in_ready  = ready_en && (count != 2'd2);
    out_valid = (count != 2'd0);
    occupancy = count;
    i_shift   = state_mem[rd_ptr];
    out_tag   = tag_mem[rd_ptr];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_mem[0] <= '0;
      state_mem[1] <= '0;
      tag_mem[0]   <= '0;
      tag_mem[1]   <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          state_mem[wr_ptr] <= shifted;
          tag_mem[wr_ptr]   <= in_tag;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
